// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter sequencing single-cycle accesses to an 8x4 SRAM.
// Every access takes exactly three cycles: IDLE (arbitrate), ACCESS (pins driven), DONE.
module sram_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqA,
  input  logic              reqB,
  input  logic              weA,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] wdataA,
  input  logic [DATA_W-1:0] wdataB,
  output logic              gntA,
  output logic              gntB,
  output logic              doneA,
  output logic              doneB,
  output logic [DATA_W-1:0] rdataA,
  output logic [DATA_W-1:0] rdataB,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memDataIn,
  output logic              memChipSelect,
  output logic              memWriteEnable,
  input  logic [DATA_W-1:0] memDataOut,
  output logic [1:0]        state_dbg
);

  // Handshake: a port holds req and its fields until it sees gnt; gnt high means
  // those fields were captured. done marks completion; rdata is valid with done on a read.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  logic   owner;       // 0 = A, 1 = B
  logic   last_grant;  // 0 = A, 1 = B
  logic   pick_b;

  // On a tie the port that did not win last time takes the access.
  assign pick_b    = reqB && (!reqA || !last_grant);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      gntA           <= 1'b0;
      gntB           <= 1'b0;
      doneA          <= 1'b0;
      doneB          <= 1'b0;
      memChipSelect  <= 1'b0;
      memWriteEnable <= 1'b0;
      memAddress     <= '0;
      memDataIn      <= '0;
      rdataA         <= '0;
      rdataB         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqA || reqB) begin
            owner          <= pick_b;
            memWriteEnable <= pick_b ? weB : weA;
            memAddress     <= pick_b ? addrB : addrA;
            memDataIn      <= pick_b ? wdataB : wdataA;
            memChipSelect  <= 1'b1;
            gntA           <= !pick_b;
            gntB           <= pick_b;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          if (!memWriteEnable) begin
            if (owner) rdataB <= memDataOut;
            else       rdataA <= memDataOut;
          end
          memChipSelect  <= 1'b0;
          memWriteEnable <= 1'b0;
          gntA           <= 1'b0;
          gntB           <= 1'b0;
          doneA          <= !owner;
          doneB          <= owner;
          last_grant     <= owner;
          state          <= DONE;
        end
        DONE: begin
          doneA <= 1'b0;
          doneB <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
